// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide engine and its HI/LO write interface.
package muldiv_unit_pkg;

  // Operations the execute stage can hand to the HI/LO producer
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } hilo_op_t;

  // Architectural HI/LO register width
  localparam int HILO_WIDTH = 32;

  // Cycles from the accept edge to the cycle in which the write is visible
  localparam int HILO_LAT = HILO_WIDTH + 2;

  // One write request towards the HI/LO register block
  typedef struct packed {
    logic                  valid;
    logic [HILO_WIDTH-1:0] data;
  } hilo_write_req;

  // True for the iterative operations (they occupy the unit for many cycles)
  function automatic logic is_muldiv_op(hilo_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // True for operations that use restoring division rather than shift-add
  function automatic logic is_div_op(hilo_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // True for operations whose operands are two's complement
  function automatic logic is_signed_op(hilo_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// engine, including the HI/LO write strobes the engine produces.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             req_valid;
  logic             req_ready;
  hilo_op_t         req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             flush;
  logic             hi_valid;
  logic [WIDTH-1:0] hi_data;
  logic             lo_valid;
  logic [WIDTH-1:0] lo_data;

  // Execute-stage side: issues operations and observes the write strobes
  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, hi_valid, hi_data, lo_valid, lo_data
  );

  // Engine side
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, hi_valid, hi_data, lo_valid, lo_data
  );

endinterface

// File: rtl/muldiv_unit_signfix.sv
// Combinational sign handling around the unsigned iterative core: takes
// magnitudes of signed operands on the way in and restores result signs
// on the way out.
module muldiv_unit_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               signed_op,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  output logic               neg_a,
  output logic               neg_b,
  input  logic [2*WIDTH-1:0] raw,
  input  logic               is_div,
  input  logic               res_neg,
  input  logic               rem_neg,
  input  logic               div_zero,
  output logic [WIDTH-1:0]   fix_hi,
  output logic [WIDTH-1:0]   fix_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // still the right unsigned magnitude for the core
  always_comb begin
    neg_a = signed_op & op_a[WIDTH-1];
    neg_b = signed_op & op_b[WIDTH-1];
    abs_a = neg_a ? -op_a : op_a;
    abs_b = neg_b ? -op_b : op_b;
  end

  // Result correction: whole product negated as one 2*WIDTH value, quotient
  // and remainder negated separately; a zero divisor forces an all-ones quotient
  always_comb begin
    prod = res_neg ? -raw : raw;
    quot = raw[WIDTH-1:0];
    rem  = raw[2*WIDTH-1:WIDTH];
    if (is_div) begin
      fix_lo = div_zero ? {WIDTH{1'b1}} : (res_neg ? -quot : quot);
      fix_hi = rem_neg ? -rem : rem;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine. One iteration per cycle on an unsigned
// core, with HI/LO written together after a final sign-fix cycle.
// MTHI/MTLO bypass the core and produce a single registered write.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;

  logic               accept;
  logic               signed_op;
  logic               div_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  logic               hi_valid;
  logic               lo_valid;
  logic [WIDTH-1:0]   hi_data;
  logic [WIDTH-1:0]   lo_data;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && (state == ST_IDLE) && !bus.flush;
  assign signed_op     = is_signed_op(bus.req_op);
  assign div_op        = is_div_op(bus.req_op);

  assign bus.hi_valid  = hi_valid;
  assign bus.lo_valid  = lo_valid;
  assign bus.hi_data   = hi_data;
  assign bus.lo_data   = lo_data;

  muldiv_unit_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .op_a     (bus.req_a),
    .op_b     (bus.req_b),
    .signed_op(signed_op),
    .abs_a    (abs_a),
    .abs_b    (abs_b),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .raw      (acc),
    .is_div   (is_div),
    .res_neg  (res_neg),
    .rem_neg  (rem_neg),
    .div_zero (div_zero),
    .fix_hi   (fix_hi),
    .fix_lo   (fix_lo)
  );

  // One core iteration: multiply keeps {partial product, multiplier} in acc
  // and shifts right; divide keeps {remainder, dividend/quotient} and shifts
  // left, committing the trial subtraction only when it does not go negative
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next  = acc;
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sequencing and datapath state; flush abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && is_muldiv_op(bus.req_op)) begin
            opnd     <= div_op ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
            is_div   <= div_op;
            res_neg  <= neg_a ^ neg_b;
            rem_neg  <= div_op & neg_a;
            div_zero <= div_op && (bus.req_b == '0);
            cnt      <= CW'(WIDTH - 1);
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // HI/LO write strobes: single-cycle pulses, never raised in a flush cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_valid <= 1'b0;
      lo_valid <= 1'b0;
      hi_data  <= '0;
      lo_data  <= '0;
    end else begin
      hi_valid <= 1'b0;
      lo_valid <= 1'b0;
      if (!bus.flush) begin
        if (state == ST_FIX) begin
          hi_valid <= 1'b1;
          lo_valid <= 1'b1;
          hi_data  <= fix_hi;
          lo_data  <= fix_lo;
        end else if (accept && (bus.req_op == MTHI)) begin
          hi_valid <= 1'b1;
          hi_data  <= bus.req_a;
        end else if (accept && (bus.req_op == MTLO)) begin
          lo_valid <= 1'b1;
          lo_data  <= bus.req_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, write timing,
// MTHI/MTLO bypass, flush and asynchronous reset behaviour.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int WRITE_CYCLE = 34;
  localparam int READY_LOW   = 33;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current cycle; returns one cycle later with
  // the request withdrawn
  task automatic applyStimulus(input string tag, input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    checkOutput({tag, " ready at issue"}, {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    next_cycle();
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
  endtask

  // Runs one iterative operation and checks result, timing and handshake
  task automatic run_op(input string tag, input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hilo_write_req seen_hi;
    hilo_write_req seen_lo;
    int   hi_cyc;
    int   lo_cyc;
    int   hi_cnt;
    int   lo_cnt;
    int   ready_low;
    logic ready_at_write;
    seen_hi        = '0;
    seen_lo        = '0;
    hi_cyc         = -1;
    lo_cyc         = -1;
    hi_cnt         = 0;
    lo_cnt         = 0;
    ready_low      = 0;
    ready_at_write = 1'b0;
    applyStimulus(tag, op, a, b);
    for (int c = 1; c <= HILO_LAT + 4; c++) begin
      @(negedge clk);
      if (bus.hi_valid) begin
        hi_cnt++;
        if (hi_cyc < 0) hi_cyc = c;
        seen_hi.valid = 1'b1;
        seen_hi.data  = bus.hi_data;
      end
      if (bus.lo_valid) begin
        lo_cnt++;
        if (lo_cyc < 0) lo_cyc = c;
        seen_lo.valid = 1'b1;
        seen_lo.data  = bus.lo_data;
      end
      if (!bus.req_ready) ready_low++;
      if (c == WRITE_CYCLE) ready_at_write = bus.req_ready;
      next_cycle();
    end
    checkOutput({tag, " hi_data"}, {32'd0, seen_hi.data}, {32'd0, exp_hi});
    checkOutput({tag, " lo_data"}, {32'd0, seen_lo.data}, {32'd0, exp_lo});
    checkOutput({tag, " hi write cycle"}, 64'(hi_cyc), 64'(WRITE_CYCLE));
    checkOutput({tag, " lo write cycle"}, 64'(lo_cyc), 64'(WRITE_CYCLE));
    checkOutput({tag, " hi pulse count"}, 64'(hi_cnt), 64'd1);
    checkOutput({tag, " lo pulse count"}, 64'(lo_cnt), 64'd1);
    checkOutput({tag, " ready low cycles"}, 64'(ready_low), 64'(READY_LOW));
    checkOutput({tag, " ready at write"}, {63'd0, ready_at_write}, 64'd1);
  endtask

  // Directed test sequence
  initial begin
    int valid_count;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;

    #12;
    checkOutput("reset ready", {63'd0, bus.req_ready}, 64'd1);
    checkOutput("reset hi_valid", {63'd0, bus.hi_valid}, 64'd0);
    checkOutput("reset lo_valid", {63'd0, bus.lo_valid}, 64'd0);
    checkOutput("reset hi_data", {32'd0, bus.hi_data}, 64'd0);
    checkOutput("reset lo_data", {32'd0, bus.lo_data}, 64'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult minneg sq", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu 7/0", DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div minneg/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI then back-to-back MTLO
    bus.req_valid = 1'b1;
    bus.req_op    = MTHI;
    bus.req_a     = 32'h1234_5678;
    next_cycle();
    bus.req_op = MTLO;
    bus.req_a  = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("mthi hi_valid", {63'd0, bus.hi_valid}, 64'd1);
    checkOutput("mthi hi_data", {32'd0, bus.hi_data}, 64'h1234_5678);
    checkOutput("mthi lo_valid", {63'd0, bus.lo_valid}, 64'd0);
    checkOutput("mthi no stall", {63'd0, bus.req_ready}, 64'd1);
    next_cycle();
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    @(negedge clk);
    checkOutput("mtlo lo_valid", {63'd0, bus.lo_valid}, 64'd1);
    checkOutput("mtlo lo_data", {32'd0, bus.lo_data}, 64'hCAFE_F00D);
    checkOutput("mtlo hi_valid", {63'd0, bus.hi_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    checkOutput("mtlo pulse ends", {62'd0, bus.hi_valid, bus.lo_valid}, 64'd0);
    next_cycle();

    // Flush during RUN
    applyStimulus("div flush run", DIV, 32'd100, 32'd3);
    repeat (9) next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush run ready before", {63'd0, bus.req_ready}, 64'd0);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush run ready after", {63'd0, bus.req_ready}, 64'd1);
    valid_count = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.hi_valid || bus.lo_valid) valid_count++;
    end
    checkOutput("flush run no write", 64'(valid_count), 64'd0);
    next_cycle();

    // Flush in the same cycle as a request
    bus.req_valid = 1'b1;
    bus.req_op    = MTHI;
    bus.req_a     = 32'hDEAD_0001;
    bus.flush     = 1'b1;
    next_cycle();
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    bus.flush     = 1'b0;
    @(negedge clk);
    checkOutput("flush same-cycle req hi_valid", {63'd0, bus.hi_valid}, 64'd0);
    checkOutput("flush same-cycle req hi_data", {32'd0, bus.hi_data}, 64'h1234_5678);
    next_cycle();

    // Flush in FIX
    applyStimulus("multu flush fix", MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (32) next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush fix ready before", {63'd0, bus.req_ready}, 64'd0);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush fix no valid", {62'd0, bus.hi_valid, bus.lo_valid}, 64'd0);
    checkOutput("flush fix ready after", {63'd0, bus.req_ready}, 64'd1);
    valid_count = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.hi_valid || bus.lo_valid) valid_count++;
    end
    checkOutput("flush fix no late write", 64'(valid_count), 64'd0);
    next_cycle();

    // Asynchronous reset in the middle of RUN
    applyStimulus("divu reset", DIVU, 32'd1000, 32'd7);
    repeat (4) next_cycle();
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset ready", {63'd0, bus.req_ready}, 64'd1);
    checkOutput("async reset valids", {62'd0, bus.hi_valid, bus.lo_valid}, 64'd0);
    checkOutput("async reset hi_data", {32'd0, bus.hi_data}, 64'd0);
    checkOutput("async reset lo_data", {32'd0, bus.lo_data}, 64'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    run_op("multu 6*7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
